// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared FSM encoding and defaults for the 74HC165 reader
package hc_pkg;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/hc165_ctrl_if.sv
// rtl/hc165_ctrl_if.sv - pin-level bus between the reader and the 74HC165 chain
interface hc165_ctrl_if;

  logic pl;
  logic cp;
  logic ce_n;
  logic q7;

  modport master (output pl, output cp, output ce_n, input q7);
  modport slave  (input pl, input cp, input ce_n, output q7);

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for slow asynchronous board inputs
module sync_2ff (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic d,
  output logic q
);

  logic meta;

  // two back-to-back flops; q is safe to use in the sys_clk domain
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hc165_ctrl.sv
// rtl/hc165_ctrl.sv - periodic scan of a 74HC165 chain into a parallel word
module hc165_ctrl
  import hc_pkg::*;
#(
  parameter int N_BITS   = 16,
  parameter int CLK_DIV  = CLK_DIV_DEFAULT,
  parameter int SCAN_GAP = 1000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  hc165_ctrl_if.master      bus,
  output logic [N_BITS-1:0] data_out,
  output logic              data_vld,
  output logic              data_chg
);

  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(N_BITS);
  localparam int GAP_W = $clog2(SCAN_GAP + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);

  logic [1:0]        state;
  logic [PH_W-1:0]   ph;
  logic [BIT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [N_BITS-1:0] shreg;
  logic              q7_s;

  sync_2ff u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .d       (bus.q7),
    .q       (q7_s)
  );

  // chain clock is held off only while the reader itself is in reset
  assign bus.ce_n = sys_rst;

  // scan sequencer: LOAD -> SHIFT (N_BITS bit periods) -> DONE -> GAP -> LOAD
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_LOAD;
      ph      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ph == PH_LAST) begin
            state <= ST_SHIFT;
            ph    <= '0;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            if (bit_cnt == BIT_LAST) begin
              state   <= ST_DONE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_GAP;
          gap_cnt <= '0;
        end
        default: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_LOAD;
            ph    <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // pin drivers: pl low one cycle behind LOAD, cp high for the second half of each bit
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bus.pl <= 1'b1;
      bus.cp <= 1'b0;
    end else begin
      bus.pl <= (state != ST_LOAD);
      bus.cp <= (state == ST_SHIFT) && (ph >= PH_HALF);
    end
  end

  // sample just before cp rises; publish the word and its change flag in DONE
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shreg    <= '0;
      data_out <= '0;
      data_vld <= 1'b0;
      data_chg <= 1'b0;
    end else begin
      data_vld <= (state == ST_DONE);
      data_chg <= (state == ST_DONE) && (shreg != data_out);
      if (state == ST_DONE) begin
        data_out <= shreg;
      end
      if ((state == ST_SHIFT) && (ph == PH_HALF)) begin
        shreg <= {shreg[N_BITS-2:0], q7_s};
      end
    end
  end

endmodule

// File: tb/tb_hc165_ctrl.sv
// tb/tb_hc165_ctrl.sv - directed self-checking bench for hc165_ctrl
module tb_hc165_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic rst2    = 1'b1;

  always #5 sys_clk = ~sys_clk;

  hc165_ctrl_if bus ();
  hc165_ctrl_if bus2 ();

  logic [15:0] data_out;
  logic        data_vld, data_chg;
  logic [7:0]  data_out2;
  logic        vld2, chg2;

  hc165_ctrl dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .data_out (data_out),
    .data_vld (data_vld),
    .data_chg (data_chg)
  );

  hc165_ctrl #(.N_BITS(8), .CLK_DIV(6), .SCAN_GAP(1)) dut2 (
    .sys_clk  (sys_clk),
    .sys_rst  (rst2),
    .bus      (bus2),
    .data_out (data_out2),
    .data_vld (vld2),
    .data_chg (chg2)
  );

  // behavioural 74HC165 x2: transparent load while pl low, shift on cp rise
  logic [15:0] par = 16'h0000;
  logic [15:0] sr  = 16'h0000;
  logic        cp_d = 1'b0;
  always @(posedge sys_clk) begin
    cp_d <= bus.cp;
    if (!bus.pl) sr <= par;
    else if (bus.cp && !cp_d) sr <= {sr[14:0], 1'b0};
  end
  assign bus.q7 = bus.pl ? sr[15] : par[15];

  // single-chip model for the 8-bit instance
  logic [7:0] par2 = 8'h00;
  logic [7:0] sr2  = 8'h00;
  logic       cp2_d = 1'b0;
  always @(posedge sys_clk) begin
    cp2_d <= bus2.cp;
    if (!bus2.pl) sr2 <= par2;
    else if (bus2.cp && !cp2_d) sr2 <= {sr2[6:0], 1'b0};
  end
  assign bus2.q7 = bus2.pl ? sr2[7] : par2[7];

  // edge counters: edge 1 is the first rising edge with reset low
  int cyc = 0, cyc2 = 0;
  always @(posedge sys_clk) begin
    cyc  <= sys_rst ? 0 : cyc + 1;
    cyc2 <= rst2 ? 0 : cyc2 + 1;
  end

  // waveform statistics gathered per scan window
  int   pl_low = 0, cp_rises = 0, rise_pl_low = 0, run_bad = 0, ce_bad = 0;
  int   hi_run = 0, lo_run = 0;
  logic had_rise = 1'b0;
  logic cp_q = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (bus.ce_n !== 1'b0) ce_bad++;
      if (!bus.pl) pl_low++;
      if (bus.cp) begin
        if (!cp_q) begin
          cp_rises++;
          if (!bus.pl) rise_pl_low++;
          if (had_rise && lo_run != 2) run_bad++;
          had_rise = 1'b1;
          hi_run = 1;
        end else begin
          hi_run++;
        end
      end else begin
        if (cp_q) begin
          if (hi_run != 2) run_bad++;
          lo_run = 1;
        end else begin
          lo_run++;
        end
      end
    end
    cp_q = bus.cp;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    pl_low = 0;
    cp_rises = 0;
    rise_pl_low = 0;
    run_bad = 0;
    had_rise = 1'b0;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pl_low"}, pl_low, 4);
    chk({tag, "_cp_rises"}, cp_rises, 16);
    chk({tag, "_rise_pl_low"}, rise_pl_low, 0);
    chk({tag, "_cp_runs"}, run_bad, 0);
  endtask

  task automatic wait_vld(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (data_vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_vld2(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (vld2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic ok;
    logic prev;
    int   t0, n;

    par  = 16'hA5C3;
    par2 = 8'h80;
    repeat (3) @(negedge sys_clk);
    chk("rst_pl", bus.pl, 1);
    chk("rst_cp", bus.cp, 0);
    chk("rst_ce_n", bus.ce_n, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_vld", data_vld, 0);
    chk("rst_chg", data_chg, 0);

    // single scan
    sys_rst = 1'b0;
    clr_stats();
    wait_vld(200, ok);
    chk("scan1_timeout", ok, 1);
    chk("scan1_edge", cyc, 69);
    chk("scan1_data", data_out, 16'hA5C3);
    chk("scan1_chg", data_chg, 1);
    chk_stats("scan1");
    clr_stats();
    t0 = cyc;

    // repeat unchanged
    wait_vld(1200, ok);
    chk("scan2_timeout", ok, 1);
    chk("scan2_period", cyc - t0, 1069);
    chk("scan2_data", data_out, 16'hA5C3);
    chk("scan2_chg", data_chg, 0);
    chk_stats("scan2");
    clr_stats();
    t0 = cyc;

    // change during GAP
    par = 16'h0001;
    wait_vld(1200, ok);
    chk("scan3_timeout", ok, 1);
    chk("scan3_period", cyc - t0, 1069);
    chk("scan3_data", data_out, 16'h0001);
    chk("scan3_chg", data_chg, 1);
    chk_stats("scan3");

    // reset after the 8th cp rise of the next scan
    n = 0;
    prev = bus.cp;
    ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge sys_clk);
      if (bus.cp && !prev) n++;
      prev = bus.cp;
      if (n == 8) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_cp8_timeout", ok, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("abort_data_out", data_out, 0);
    chk("abort_pl", bus.pl, 1);
    chk("abort_cp", bus.cp, 0);
    chk("abort_ce_n", bus.ce_n, 1);
    chk("abort_vld", data_vld, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    clr_stats();
    wait_vld(200, ok);
    chk("restart_timeout", ok, 1);
    chk("restart_edge", cyc, 69);
    chk("restart_data", data_out, 16'h0001);
    chk("restart_chg", data_chg, 1);
    chk_stats("restart");
    chk("ce_n_outside_reset", ce_bad, 0);

    // parameter sweep: 8 bits, CLK_DIV 6, SCAN_GAP 1
    rst2 = 1'b0;
    wait_vld2(200, ok);
    chk("sweep1_timeout", ok, 1);
    chk("sweep1_edge", cyc2, 55);
    chk("sweep1_data", data_out2, 8'h80);
    chk("sweep1_chg", chg2, 1);
    t0 = cyc2;
    wait_vld2(200, ok);
    chk("sweep2_timeout", ok, 1);
    chk("sweep2_period", cyc2 - t0, 56);
    chk("sweep2_data", data_out2, 8'h80);
    chk("sweep2_chg", chg2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
